macc_seq: RTL and testbench
===========================

MACC_SEQ -- requirements
Module: macc_seq

Interface
REQ-001 Parameter MUL_LAT, default 8: rising edges from a change on mul_x/mul_y until mul_p is stable for those operands.
REQ-002 Parameter ACC_W, default 24: accumulator/result width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a dot-product job; sampled only in IDLE.
REQ-006 len  input  8  number of operand pairs in the job (0..255); sampled with start.
REQ-007 abort  input  1  synchronous job cancel.
REQ-008 in_valid  input  1  operand pair valid.
REQ-009 in_ready  output  1  operand pair accepted when in_valid & in_ready.
REQ-010 in_x, in_y  input  8 each  signed two's-complement operands.
REQ-011 mul_x, mul_y  output  8 each  registered operands driven to the shared Booth multiplier.
REQ-012 mul_p  input  15  signed product returned by the multiplier.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  result consumed when out_valid & out_ready.
REQ-015 out_acc  output  ACC_W  signed accumulated dot product.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, FETCH, HOLD, RESULT.
REQ-018 IDLE & start & len!=0: clear accumulator, load remaining count with len, go to FETCH.
REQ-019 IDLE & start & len==0: clear accumulator and go to RESULT. out_valid is high on the next cycle with out_acc=0.
REQ-020 FETCH: in_ready=1 (combinational on state). in_ready=0 in all other states.
REQ-021 On handshake in FETCH: load mul_x<=in_x and mul_y<=in_y, load hold counter, go to HOLD.
REQ-022 HOLD: mul_x and mul_y stay stable. The product is sampled at the (MUL_LAT+1)-th rising edge after the loading edge.
REQ-023 At the sample edge: acc <= acc + sign-extend(mul_p); decrement remaining count. Go to FETCH if remaining count > 0 after the decrement, else go to RESULT.
REQ-024 Special case mul_x==8'h80 and mul_y==8'h80: the product does not fit in 15 signed bits. At the sample edge, add +16384 instead of mul_p.
REQ-025 Throughput with in_valid held high: one pair per MUL_LAT+2 cycles.
REQ-026 Job latency: for start accepted at edge S and no input stalls, out_valid rises after edge S + len*(MUL_LAT+2).
REQ-027 No accumulator overflow is possible: |sum| <= 255*16384 < 2^23. Arithmetic is modulo 2^ACC_W with no saturation.
REQ-028 RESULT: out_valid=1 and out_acc is stable until the handshake. The handshake moves the FSM to IDLE with out_valid=0 on the next cycle.
REQ-029 start is ignored outside IDLE, including the RESULT handshake cycle.
REQ-030 abort has priority over all other transitions in FETCH, HOLD and RESULT. Effects:
- next state IDLE;
- the in-flight product is discarded;
- out_valid drops;
- the accumulator retains its value but is not presented.
REQ-031 In IDLE, abort has no effect. abort and start in the same IDLE cycle: abort wins, and the job does not start.
REQ-032 mul_x and mul_y change only on a FETCH handshake. They retain their last value in all other states.
REQ-033 If in_valid is low in FETCH, the FSM waits indefinitely without timeout, and the accumulator is unchanged.

Reset
REQ-034 rst_n low asynchronously forces all of the following, at any point including mid-HOLD:
- state=IDLE;
- mul_x=0, mul_y=0;
- accumulator=0;
- out_acc=0;
- out_valid=0, in_ready=0, busy=0;
- hold and remaining counters=0.
REQ-035 After reset release, no output changes until start is sampled in IDLE.

Verification
REQ-036 len=1, pair (3,-5), in_valid high, out_ready high -> out_acc=24'hFFFFF1 (-15). out_valid rises after start edge +10 cycles (MUL_LAT=8).
REQ-037 len=4, pairs (127,127),(-128,127),(-1,-1),(0,55) -> out_acc=16129-16256+1+0=-126=24'hFFFF82. in_ready pulses exactly 4 times, 10 cycles apart.
REQ-038 len=2, pairs (-128,-128),(-128,-128) -> out_acc=32768=24'h008000, exercising the REQ-024 bypass.
REQ-039 len=0 start -> out_valid on the next cycle with out_acc=0. Hold out_ready low 5 cycles -> out_valid/out_acc stable. A start pulse during RESULT is ignored.
REQ-040 len=3 with in_valid dropped 7 cycles before the 2nd pair, then abort asserted mid-HOLD of the 3rd pair -> IDLE on the next cycle, busy=0, no out_valid. A new len=1 job (2,2) then yields out_acc=4.
REQ-041 rst_n asserted mid-HOLD -> all outputs at reset values immediately. After release, a len=1 (-7,9) job yields out_acc=24'hFFFFC1 (-63).

Source files
------------

// File: rtl/macc_seq.sv
// macc_seq: sequential signed 8x8 multiply-accumulate (dot-product) engine.
// A job of `len` operand pairs goes through a shared external multiplier with
// a fixed latency of MUL_LAT edges. Each pair is presented on mul_x/mul_y and
// held there, and the product is added to a signed accumulator once it has
// settled. The final sum is then offered on a valid/ready result port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, len        job start (sampled in IDLE) and pair count (0..255)
//   abort             synchronous job cancel (ignored in IDLE)
//   in_valid/in_ready operand pair handshake; in_x, in_y signed operands
//   mul_x, mul_y      registered operands to the shared multiplier
//   mul_p             signed 15-bit product returned by the multiplier
//   out_valid/ready   result handshake; out_acc signed dot product
//   busy              high whenever the engine is not IDLE
module macc_seq #(
  parameter int MUL_LAT = 8,
  parameter int ACC_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  output logic [7:0]       mul_x,
  output logic [7:0]       mul_y,
  input  logic [14:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             busy
);

  localparam int HW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_RESULT
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] oacc_q, oacc_d;
  logic [7:0]       rem_q, rem_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [7:0]       mx_q, mx_d;
  logic [7:0]       my_q, my_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;

  // (-128)*(-128) = +16384 is one past the largest 15-bit signed value, so
  // the multiplier cannot return it; substitute the true product here.
  always_comb begin
    if (mx_q == 8'h80 && my_q == 8'h80) begin
      prod_ext = ACC_W'(16384);
    end else begin
      prod_ext = {{(ACC_W-15){mul_p[14]}}, mul_p};
    end
    acc_sum = acc_q + prod_ext;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    oacc_d  = oacc_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    mx_d    = mx_q;
    my_d    = my_q;

    case (state_q)
      S_IDLE: begin
        // abort in the same cycle suppresses the start entirely
        if (start && !abort) begin
          acc_d = '0;
          if (len == 8'd0) begin
            oacc_d  = '0;
            state_d = S_RESULT;
          end else begin
            rem_d   = len;
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          mx_d    = in_x;
          my_d    = in_y;
          hold_d  = HW'(MUL_LAT);
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        // hold_q counts down MUL_LAT edges; the edge that sees zero is the
        // (MUL_LAT+1)-th after the operand load and samples the product.
        if (abort) begin
          hold_d  = '0;
          state_d = S_IDLE;
        end else if (hold_q == '0) begin
          acc_d = acc_sum;
          rem_d = rem_q - 8'd1;
          if (rem_q != 8'd1) begin
            state_d = S_FETCH;
          end else begin
            oacc_d  = acc_sum;
            state_d = S_RESULT;
          end
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end

      S_RESULT: begin
        if (abort || out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      oacc_q  <= '0;
      rem_q   <= '0;
      hold_q  <= '0;
      mx_q    <= '0;
      my_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      oacc_q  <= oacc_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
    end
  end

  assign in_ready  = (state_q == S_FETCH);
  assign out_valid = (state_q == S_RESULT);
  assign busy      = (state_q != S_IDLE);
  assign mul_x     = mx_q;
  assign mul_y     = my_q;
  assign out_acc   = oacc_q;

endmodule

// File: tb/tb_macc_seq.sv
// Testbench for macc_seq: directed jobs with hand-computed dot products.
// A pipelined multiplier model feeds mul_p. Expected results are queued
// when each job starts, and a monitor pops and compares them on every
// result handshake.
module tb_macc_seq;

  localparam int MUL_LAT = 8;
  localparam int ACC_W   = 24;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [7:0]       len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_x;
  logic [7:0]       in_y;
  logic [7:0]       mul_x;
  logic [7:0]       mul_y;
  logic [14:0]      mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             busy;

  macc_seq #(.MUL_LAT(MUL_LAT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: product appears MUL_LAT edges after the operands change;
  // before that mul_p still shows products of older operands.
  logic signed [15:0] full_p;
  logic [14:0]        pipe [MUL_LAT];
  assign full_p = $signed(mul_x) * $signed(mul_y);
  assign mul_p  = pipe[MUL_LAT-1];
  always @(posedge clk) begin
    pipe[0] <= full_p[14:0];
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end

  int checks   = 0;
  int failures = 0;
  logic [ACC_W-1:0] exp_q [$];
  int rdy_cnt = 0;

  always @(negedge clk) if (in_ready) rdy_cnt++;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result out_acc=%h required=none", out_acc);
      end else begin
        logic [ACC_W-1:0] e;
        e = exp_q.pop_front();
        if (out_acc !== e) begin
          failures++;
          $display("FAIL result out_acc=%h required=%h", out_acc, e);
        end else begin
          $display("result out_acc=%h ok", out_acc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] l, output int s);
    start = 1'b1;
    len   = l;
    tick();
    s     = cyc;
    start = 1'b0;
    $display("start len=%0d at edge %0d", l, s);
  endtask

  // Presents a pair and waits (bounded) for the handshake edge; hc = that edge.
  task automatic send(input logic [7:0] x, input logic [7:0] y, output int hc);
    int n;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    n        = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
      hc = cyc;
    end else begin
      tick();
      hc = cyc;
      chk("mul_x_load", 32'(mul_x), 32'(x));
      chk("mul_y_load", 32'(mul_y), 32'(y));
      $display("pair x=%h y=%h accepted at edge %0d", x, y, hc);
    end
  endtask

  // Waits (bounded) for out_valid, then passes the handshake edge.
  task automatic wait_out(output int rc);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    rc = cyc;
    if (n >= 300) chk("result_timeout", 32'(out_valid), 32'd1);
    tick();
    chk("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mul_x"}, 32'(mul_x), 32'd0);
    chk({tag, "_mul_y"}, 32'(mul_y), 32'd0);
    chk({tag, "_out_acc"}, 32'(out_acc), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int s, hc, rc, r0;
    int hcs [4];
    logic [7:0] t2x [4];
    logic [7:0] t2y [4];
    t2x = '{8'd127, 8'h80, 8'hFF, 8'd0};
    t2y = '{8'd127, 8'd127, 8'hFF, 8'd55};

    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
    tick(); tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(); tick();

    // single pair (3,-5), latency 10
    exp_q.push_back(24'hFFFFF1);
    start_job(8'd1, s);
    send(8'd3, 8'hFB, hc);
    in_valid = 1'b0;
    chk("t1_first_hs", 32'(hc - s), 32'd1);
    wait_out(rc);
    chk("t1_latency", 32'(rc - s), 32'd10);

    // four pairs, in_valid held high, throughput 10
    exp_q.push_back(24'hFFFF82);
    r0 = rdy_cnt;
    start_job(8'd4, s);
    for (int i = 0; i < 4; i++) send(t2x[i], t2y[i], hcs[i]);
    in_valid = 1'b0;
    chk("t2_first_hs", 32'(hcs[0] - s), 32'd1);
    for (int i = 1; i < 4; i++) chk("t2_hs_spacing", 32'(hcs[i] - hcs[i-1]), 32'd10);
    wait_out(rc);
    chk("t2_latency", 32'(rc - s), 32'd40);
    chk("t2_in_ready_pulses", 32'(rdy_cnt - r0), 32'd4);

    // (-128)*(-128) bypass twice
    exp_q.push_back(24'h008000);
    start_job(8'd2, s);
    send(8'h80, 8'h80, hc);
    send(8'h80, 8'h80, hc);
    in_valid = 1'b0;
    wait_out(rc);

    // len=0, stalled result, start ignored in RESULT
    out_ready = 1'b0;
    exp_q.push_back(24'h000000);
    start_job(8'd0, s);
    chk("t4_valid_next", 32'(out_valid), 32'd1);
    chk("t4_acc_zero", 32'(out_acc), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1'b1; len = 8'd3; end
      tick();
      start = 1'b0;
      chk("t4_valid_stall", 32'(out_valid), 32'd1);
      chk("t4_acc_stall", 32'(out_acc), 32'd0);
    end
    out_ready = 1'b1;
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    chk("t4_after_hs_valid", 32'(out_valid), 32'd0);
    chk("t4_after_hs_busy", 32'(busy), 32'd0);

    // start with abort in IDLE: job must not start
    start = 1'b1; abort = 1'b1; len = 8'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);

    // stalled FETCH, then abort mid-HOLD of the third pair
    start_job(8'd3, s);
    send(8'd1, 8'd1, hc);
    in_valid = 1'b0;
    for (int n = 0; n < 300 && !in_ready; n++) tick();
    repeat (7) tick();
    chk("t5_fetch_wait", 32'(in_ready), 32'd1);
    chk("t5_mul_x_kept", 32'(mul_x), 32'd1);
    send(8'd2, 8'd2, hc);
    send(8'd3, 8'd3, hc);
    in_valid = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_valid", 32'(out_valid), 32'd0);
    chk("t5_abort_ready", 32'(in_ready), 32'd0);
    chk("t5_abort_mul_x", 32'(mul_x), 32'd3);
    repeat (20) tick();
    exp_q.push_back(24'h000004);
    start_job(8'd1, s);
    send(8'd2, 8'd2, hc);
    in_valid = 1'b0;
    wait_out(rc);

    // asynchronous reset mid-HOLD
    start_job(8'd2, s);
    send(8'd5, 8'd5, hc);
    in_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("post_rst");
    exp_q.push_back(24'hFFFFC1);
    start_job(8'd1, s);
    send(8'hF9, 8'd9, hc);
    in_valid = 1'b0;
    wait_out(rc);
    chk("t6_latency", 32'(rc - s), 32'd10);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
